// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcode/funct
// constants, datapath select encodings (same as the single-cycle decoder),
// the sequencing state enum and the instruction-class enum.
package control_pkg;

  // Opcodes
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // Funct7 / Funct3 values that change decoding
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SR      = 3'b101;

  // ALUOp
  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b1000;
  localparam logic [3:0] ALU_SRA    = 4'b1101;
  localparam logic [3:0] ALU_PASS_B = 4'b1001;

  // ImmSrc
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_U = 3'b010;
  localparam logic [2:0] IMM_B = 3'b101;
  localparam logic [2:0] IMM_J = 3'b110;

  // RUDataWrSrc
  localparam logic [1:0] WB_ALU    = 2'b00;
  localparam logic [1:0] WB_MEM    = 2'b01;
  localparam logic [1:0] WB_PC4    = 2'b10;
  localparam logic [1:0] WB_MULDIV = 2'b11;

  // BrOp
  localparam logic [4:0] BR_NONE = 5'b00000;
  localparam logic [4:0] BR_JUMP = 5'b10000;
  localparam logic [1:0] BR_COND = 2'b01;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXECUTE, MEM, MULDIV, WB, TRAP
  } state_t;

  typedef enum logic [3:0] {
    CLS_R, CLS_I, CLS_L, CLS_S, CLS_B, CLS_JAL, CLS_JALR,
    CLS_LUI, CLS_AUIPC, CLS_M, CLS_ILLEGAL
  } iclass_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit bus: instruction-register fields and memory ready handshakes
// into the control unit, datapath/memory control and status out of it.
//   master : the control unit (consumes IR fields/readies, drives controls)
//   slave  : datapath / memory side
interface multicycle_control_unit_if #(
  parameter int unsigned INSTRET_W = 32
);
  logic [6:0]           OpCode;
  logic [2:0]           Funct3;
  logic [6:0]           Funct7;
  logic                 IMReady;
  logic                 DMReady;
  logic                 IMRd;
  logic                 IRWr;
  logic                 PCWr;
  logic                 RUWr;
  logic                 ALUASrc;
  logic                 ALUBSrc;
  logic [3:0]           ALUOp;
  logic [2:0]           ImmSrc;
  logic [4:0]           BrOp;
  logic                 DMRd;
  logic                 DMWr;
  logic [2:0]           DMCtrl;
  logic [1:0]           RUDataWrSrc;
  logic                 MulDivEn;
  logic [2:0]           MulDivOp;
  logic                 Retire;
  logic [INSTRET_W-1:0] InstRet;
  logic                 Illegal;

  modport master (
    input  OpCode, Funct3, Funct7, IMReady, DMReady,
    output IMRd, IRWr, PCWr, RUWr, ALUASrc, ALUBSrc, ALUOp, ImmSrc, BrOp,
           DMRd, DMWr, DMCtrl, RUDataWrSrc, MulDivEn, MulDivOp, Retire,
           InstRet, Illegal
  );

  modport slave (
    output OpCode, Funct3, Funct7, IMReady, DMReady,
    input  IMRd, IRWr, PCWr, RUWr, ALUASrc, ALUBSrc, ALUOp, ImmSrc, BrOp,
           DMRd, DMWr, DMCtrl, RUDataWrSrc, MulDivEn, MulDivOp, Retire,
           InstRet, Illegal
  );
endinterface

// File: rtl/multicycle_control_unit_instr_class_decoder.sv
// Combinational instruction classifier.
//   opcode/funct3/funct7 : instruction-register fields
//   iclass               : instruction class (CLS_ILLEGAL for anything unknown)
//   alu_op, imm_src      : ALU operation and immediate format
//   alu_a_src, alu_b_src : ALU operand selects (A: 0 rs1/1 PC, B: 0 rs2/1 imm)
module instr_class_decoder
  import control_pkg::*;
#(
  parameter int unsigned ENABLE_M = 1
) (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output iclass_t    iclass,
  output logic [3:0] alu_op,
  output logic [2:0] imm_src,
  output logic       alu_a_src,
  output logic       alu_b_src
);

  always_comb begin
    iclass    = CLS_ILLEGAL;
    alu_op    = ALU_ADD;
    imm_src   = IMM_I;
    alu_a_src = 1'b0;
    alu_b_src = 1'b0;
    case (opcode)
      OP_R: begin
        // funct7 0100000 is only meaningful for SUB and SRA
        if (funct7 == F7_BASE ||
            (funct7 == F7_ALT && (funct3 == F3_ADD_SUB || funct3 == F3_SR))) begin
          iclass = CLS_R;
          alu_op = {funct7[5], funct3};
        end else if (funct7 == F7_MULDIV && ENABLE_M != 0) begin
          iclass = CLS_M;
        end
      end
      OP_I: begin
        iclass    = CLS_I;
        alu_b_src = 1'b1;
        // only the shift-right immediate form carries the arithmetic bit
        alu_op    = (funct3 == F3_SR) ? {funct7[5], funct3} : {1'b0, funct3};
      end
      OP_L: begin
        iclass    = CLS_L;
        alu_b_src = 1'b1;
      end
      OP_S: begin
        iclass    = CLS_S;
        alu_b_src = 1'b1;
        imm_src   = IMM_S;
      end
      OP_B: begin
        iclass    = CLS_B;
        alu_a_src = 1'b1;
        alu_b_src = 1'b1;
        imm_src   = IMM_B;
      end
      OP_JAL: begin
        iclass    = CLS_JAL;
        alu_a_src = 1'b1;
        alu_b_src = 1'b1;
        imm_src   = IMM_J;
      end
      OP_JALR: begin
        iclass    = CLS_JALR;
        alu_b_src = 1'b1;
      end
      OP_LUI: begin
        iclass    = CLS_LUI;
        alu_b_src = 1'b1;
        imm_src   = IMM_U;
        alu_op    = ALU_PASS_B;
      end
      OP_AUIPC: begin
        iclass    = CLS_AUIPC;
        alu_a_src = 1'b1;
        alu_b_src = 1'b1;
        imm_src   = IMM_U;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control unit. Sequences each instruction through
// FETCH/DECODE/EXECUTE/(MEM|MULDIV)/WB with instruction- and data-memory
// ready handshakes, traps illegal instructions and counts retirements.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : control bus (master side) - IR fields, ready inputs, all controls
module multicycle_control_unit
  import control_pkg::*;
#(
  parameter int unsigned ENABLE_M      = 1,
  parameter int unsigned MULDIV_CYCLES = 32,
  parameter int unsigned INSTRET_W     = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  multicycle_control_unit_if.master     bus
);

  localparam logic [7:0] MD_LOAD = 8'(MULDIV_CYCLES - 1);

  state_t               state, state_n;
  logic [7:0]           md_cnt, md_cnt_n;
  logic [INSTRET_W-1:0] instret;
  logic                 retire;

  iclass_t    iclass;
  logic [3:0] alu_op;
  logic [2:0] imm_src;
  logic       alu_a_src;
  logic       alu_b_src;

  instr_class_decoder #(
    .ENABLE_M (ENABLE_M)
  ) u_dec (
    .opcode    (bus.OpCode),
    .funct3    (bus.Funct3),
    .funct7    (bus.Funct7),
    .iclass    (iclass),
    .alu_op    (alu_op),
    .imm_src   (imm_src),
    .alu_a_src (alu_a_src),
    .alu_b_src (alu_b_src)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FETCH;
      md_cnt  <= '0;
      instret <= '0;
    end else begin
      state  <= state_n;
      md_cnt <= md_cnt_n;
      if (retire) instret <= instret + INSTRET_W'(1);
    end
  end

  assign bus.InstRet = instret;

  // Outputs are decoded from state (plus the ready inputs where a handshake
  // completes). Decoding is skipped while rst is high so every request drops
  // the instant reset is asserted, including the FETCH read request.
  always_comb begin
    state_n         = state;
    md_cnt_n        = md_cnt;
    retire          = 1'b0;
    bus.IMRd        = 1'b0;
    bus.IRWr        = 1'b0;
    bus.PCWr        = 1'b0;
    bus.RUWr        = 1'b0;
    bus.ALUASrc     = 1'b0;
    bus.ALUBSrc     = 1'b0;
    bus.ALUOp       = '0;
    bus.ImmSrc      = '0;
    bus.BrOp        = BR_NONE;
    bus.DMRd        = 1'b0;
    bus.DMWr        = 1'b0;
    bus.DMCtrl      = '0;
    bus.RUDataWrSrc = WB_ALU;
    bus.MulDivEn    = 1'b0;
    bus.MulDivOp    = '0;
    bus.Illegal     = 1'b0;

    if (!rst) begin
      // ALU controls stay valid from EXECUTE through WB so the result used
      // for memory addresses, write-back and jump targets is stable.
      if (state == EXECUTE || state == MEM || state == WB) begin
        bus.ALUASrc = alu_a_src;
        bus.ALUBSrc = alu_b_src;
        bus.ALUOp   = alu_op;
        bus.ImmSrc  = imm_src;
      end

      case (state)
        FETCH: begin
          bus.IMRd = 1'b1;
          if (bus.IMReady) begin
            bus.IRWr = 1'b1;
            state_n  = DECODE;
          end
        end
        DECODE: begin
          case (iclass)
            CLS_ILLEGAL: state_n = TRAP;
            CLS_M: begin
              md_cnt_n = MD_LOAD;
              state_n  = MULDIV;
            end
            default: state_n = EXECUTE;
          endcase
        end
        EXECUTE: begin
          if (iclass == CLS_B) begin
            bus.PCWr = 1'b1;
            bus.BrOp = {BR_COND, bus.Funct3};
            retire   = 1'b1;
            state_n  = FETCH;
          end else if (iclass == CLS_L || iclass == CLS_S) begin
            state_n = MEM;
          end else begin
            state_n = WB;
          end
        end
        MEM: begin
          bus.DMCtrl = bus.Funct3;
          if (iclass == CLS_L) bus.DMRd = 1'b1;
          else                 bus.DMWr = 1'b1;
          if (bus.DMReady) begin
            if (iclass == CLS_L) begin
              state_n = WB;
            end else begin
              bus.PCWr = 1'b1;
              retire   = 1'b1;
              state_n  = FETCH;
            end
          end
        end
        MULDIV: begin
          bus.MulDivEn = 1'b1;
          bus.MulDivOp = bus.Funct3;
          if (md_cnt == '0) state_n  = WB;
          else              md_cnt_n = md_cnt - 8'd1;
        end
        WB: begin
          bus.RUWr = 1'b1;
          bus.PCWr = 1'b1;
          retire   = 1'b1;
          state_n  = FETCH;
          case (iclass)
            CLS_L:  bus.RUDataWrSrc = WB_MEM;
            CLS_M:  bus.RUDataWrSrc = WB_MULDIV;
            CLS_JAL, CLS_JALR: begin
              bus.RUDataWrSrc = WB_PC4;
              bus.BrOp        = BR_JUMP;
            end
            default: bus.RUDataWrSrc = WB_ALU;
          endcase
        end
        TRAP: begin
          bus.Illegal = 1'b1;
        end
        default: state_n = FETCH;
      endcase
    end

    bus.Retire = retire;
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

  logic clk = 1'b0;
  logic rst;
  logic rst1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  multicycle_control_unit_if #(.INSTRET_W(32)) bus0 ();
  multicycle_control_unit_if #(.INSTRET_W(32)) bus1 ();

  assign bus1.OpCode  = bus0.OpCode;
  assign bus1.Funct3  = bus0.Funct3;
  assign bus1.Funct7  = bus0.Funct7;
  assign bus1.IMReady = bus0.IMReady;
  assign bus1.DMReady = bus0.DMReady;

  multicycle_control_unit #(
    .ENABLE_M      (1),
    .MULDIV_CYCLES (4),
    .INSTRET_W     (32)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.master)
  );

  multicycle_control_unit #(
    .ENABLE_M      (0),
    .MULDIV_CYCLES (4),
    .INSTRET_W     (32)
  ) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1.master)
  );

  // pulse counters sampled mid-cycle
  int pcwr_n = 0, retire_n = 0, ruwr_n = 0, dmrd_n = 0, dmwr_n = 0;
  int muldiv_n = 0, clash_n = 0, wr1_n = 0;
  always @(negedge clk) begin
    if (bus0.PCWr)               pcwr_n++;
    if (bus0.Retire)             retire_n++;
    if (bus0.RUWr)               ruwr_n++;
    if (bus0.DMRd)               dmrd_n++;
    if (bus0.DMWr)               dmwr_n++;
    if (bus0.MulDivEn)           muldiv_n++;
    if (bus0.RUWr && bus0.DMWr)  clash_n++;
    if (bus1.RUWr || bus1.PCWr || bus1.DMWr) wr1_n++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fields(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    bus0.OpCode = op;
    bus0.Funct3 = f3;
    bus0.Funct7 = f7;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst  = 1'b1;
    rst1 = 1'b1;
    fields(7'b0, 3'b0, 7'b0);
    bus0.IMReady = 1'b0;
    bus0.DMReady = 1'b0;
    repeat (2) tick();
    check("rst_imrd",    32'(bus0.IMRd), 32'd0);
    check("rst_instret", bus0.InstRet,   32'd0);
    check("rst_illegal", 32'(bus0.Illegal), 32'd0);
    rst = 1'b0;
    #1;
    check("fetch_wait_imrd", 32'(bus0.IMRd), 32'd1);
    check("fetch_wait_irwr", 32'(bus0.IRWr), 32'd0);

    // ADD
    fields(7'b0110011, 3'b000, 7'b0000000);
    bus0.IMReady = 1'b1;
    #1;
    check("add_fetch_irwr", 32'(bus0.IRWr), 32'd1);
    tick();
    check("add_dec_imrd", 32'(bus0.IMRd), 32'd0);
    tick();
    check("add_ex_aluop", 32'(bus0.ALUOp), 32'h0);
    check("add_ex_ruwr",  32'(bus0.RUWr),  32'd0);
    tick();
    check("add_wb_ruwr",   32'(bus0.RUWr),   32'd1);
    check("add_wb_pcwr",   32'(bus0.PCWr),   32'd1);
    check("add_wb_retire", 32'(bus0.Retire), 32'd1);
    check("add_wb_src",    32'(bus0.RUDataWrSrc), 32'd0);
    tick();
    check("add_instret",   bus0.InstRet, 32'd1);
    check("add_retire_n",  retire_n,     32'd1);

    // LW, DMReady arrives in the 4th MEM cycle
    fields(7'b0000011, 3'b010, 7'b0000000);
    tick();
    tick();
    check("lw_ex_bsrc", 32'(bus0.ALUBSrc), 32'd1);
    check("lw_ex_dmrd", 32'(bus0.DMRd),    32'd0);
    tick();
    check("lw_mem_dmctrl", 32'(bus0.DMCtrl), 32'd2);
    tick();
    tick();
    tick();
    bus0.DMReady = 1'b1;
    #1;
    check("lw_mem4_dmrd",   32'(bus0.DMRd),   32'd1);
    check("lw_mem4_retire", 32'(bus0.Retire), 32'd0);
    tick();
    bus0.DMReady = 1'b0;
    #1;
    check("lw_wb_src",  32'(bus0.RUDataWrSrc), 32'd1);
    check("lw_wb_ruwr", 32'(bus0.RUWr),        32'd1);
    check("lw_wb_dmrd", 32'(bus0.DMRd),        32'd0);
    tick();
    check("lw_dmrd_n",   dmrd_n,        32'd4);
    check("lw_instret",  bus0.InstRet,  32'd2);

    // SW with DMReady already high
    fields(7'b0100011, 3'b010, 7'b0000000);
    bus0.DMReady = 1'b1;
    tick();
    tick();
    check("sw_ex_imm",  32'(bus0.ImmSrc), 32'd1);
    check("sw_ex_dmwr", 32'(bus0.DMWr),   32'd0);
    tick();
    check("sw_mem_dmwr",   32'(bus0.DMWr),   32'd1);
    check("sw_mem_pcwr",   32'(bus0.PCWr),   32'd1);
    check("sw_mem_retire", 32'(bus0.Retire), 32'd1);
    check("sw_mem_ruwr",   32'(bus0.RUWr),   32'd0);
    tick();
    bus0.DMReady = 1'b0;
    check("sw_dmwr_n",  dmwr_n,       32'd1);
    check("sw_ruwr_n",  ruwr_n,       32'd2);
    check("sw_instret", bus0.InstRet, 32'd3);

    // MUL, 4 MULDIV cycles
    fields(7'b0110011, 3'b000, 7'b0000001);
    tick();
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      check("mul_en", 32'(bus0.MulDivEn), 32'd1);
      check("mul_ruwr", 32'(bus0.RUWr),   32'd0);
    end
    tick();
    check("mul_wb_en",   32'(bus0.MulDivEn),    32'd0);
    check("mul_wb_src",  32'(bus0.RUDataWrSrc), 32'd3);
    check("mul_wb_ruwr", 32'(bus0.RUWr),        32'd1);
    tick();
    check("mul_cycles",   muldiv_n,     32'd4);
    check("mul_instret",  bus0.InstRet, 32'd4);

    // DIV interrupted by reset in its second MULDIV cycle
    fields(7'b0110011, 3'b100, 7'b0000001);
    tick();
    tick();
    tick();
    check("div_op", 32'(bus0.MulDivOp), 32'd4);
    #2 rst = 1'b1;
    #1;
    check("div_rst_en",      32'(bus0.MulDivEn), 32'd0);
    check("div_rst_imrd",    32'(bus0.IMRd),     32'd0);
    check("div_rst_instret", bus0.InstRet,       32'd0);
    fields(7'b1100011, 3'b000, 7'b0000000);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("div_rel_imrd", 32'(bus0.IMRd), 32'd1);

    // BEQ then an illegal opcode
    tick();
    tick();
    check("beq_brop",   32'(bus0.BrOp),    32'h08);
    check("beq_pcwr",   32'(bus0.PCWr),    32'd1);
    check("beq_retire", 32'(bus0.Retire),  32'd1);
    check("beq_asrc",   32'(bus0.ALUASrc), 32'd1);
    check("beq_imm",    32'(bus0.ImmSrc),  32'd5);
    tick();
    check("beq_instret", bus0.InstRet, 32'd1);
    fields(7'b1111111, 3'b000, 7'b0000000);
    tick();
    check("ill_dec_flag", 32'(bus0.Illegal), 32'd0);
    tick();
    check("ill_trap_flag", 32'(bus0.Illegal), 32'd1);
    check("ill_trap_imrd", 32'(bus0.IMRd),    32'd0);
    repeat (3) tick();
    check("ill_sticky",   32'(bus0.Illegal), 32'd1);
    check("ill_instret",  bus0.InstRet,      32'd1);
    check("ill_pcwr_n",   pcwr_n,            32'd5);
    check("ill_retire_n", retire_n,          32'd5);

    // MUL with the M extension disabled
    fields(7'b0110011, 3'b000, 7'b0000001);
    rst1 = 1'b0;
    #1;
    check("nom_fetch_irwr", 32'(bus1.IRWr), 32'd1);
    tick();
    tick();
    check("nom_illegal", 32'(bus1.Illegal),  32'd1);
    check("nom_en",      32'(bus1.MulDivEn), 32'd0);
    repeat (2) tick();
    check("nom_writes",  wr1_n,         32'd0);
    check("nom_instret", bus1.InstRet,  32'd0);

    check("ruwr_dmwr_clash", clash_n, 32'd0);
    rst = 1'b1;
    #1;
    check("final_rst_illegal", 32'(bus0.Illegal), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
